uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one byte-level UART transmitter among N_REQ requesters.
- Accepts bytes over a valid/ready handshake and issues them one at a time to the transmitter (tx_start/tx_data/tx_done).
- Locks ownership to one requester until that requester's last byte, so messages are never interleaved.
- Sits between application sources (e.g. button-triggered message generators) and the serializer; adds timeout supervision on both sides.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- clk_rate, 27000000, system clock in Hz.
- baud_rate, 115200, line rate; clk_div = clk_rate/baud_rate (234 at defaults).
- GAP_CYCLES, 0, idle clocks inserted after each tx_done before the next byte is accepted.
- DONE_TIMEOUT, 12*clk_div, max clocks from tx_start to tx_done before abort.
- HOLD_TIMEOUT, 16*clk_div, max clocks the lock owner may leave req_valid low mid-message.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock domain, synchronous, active-high.
- req_valid  in  N_REQ  byte offered by requester i.
- req_data  in  8*N_REQ  byte of requester i at bits [8i+7:8i].
- req_last  in  N_REQ  offered byte is last of message.
- req_ready  out  N_REQ  one-cycle one-hot pulse; byte i accepted this cycle.
- tx_start  out  1  one-cycle pulse to transmitter.
- tx_data  out  8  byte to send; stable from tx_start until tx_done.
- tx_done  in  1  one-cycle pulse from transmitter after stop bit.
- owner  out  clog2(N_REQ)  index of current/last grantee.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  one-cycle pulse on DONE_TIMEOUT abort.
- err_abandon  out  1  one-cycle pulse on HOLD_TIMEOUT release.

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; req_ready=0, tx_start=0, tx_data=8'h00, owner=0, busy=0, err_*=0; rr pointer last_grant=N_REQ-1 so the first search starts at 0; all counters 0.
- States: IDLE, SEND, WAIT_DONE, GAP, HOLD.
- IDLE: if any req_valid, pick the first asserted index scanning last_grant+1 upward with wrap. In the same cycle: owner<=i, tx_data<=req_data[i], req_ready[i]=1, lock<=~req_last[i]; next state SEND. If none is valid, stay in IDLE.
- SEND: tx_start=1 for exactly this cycle; timeout counter cleared; go to WAIT_DONE. tx_done in SEND is ignored.
- WAIT_DONE: count up each clock.
  - tx_done=1: go to GAP if GAP_CYCLES>0, else go directly to the post-byte decision.
  - count reaches DONE_TIMEOUT-1 with no tx_done: pulse err_timeout, clear lock, last_grant<=owner, go to IDLE.
  - tx_done and timeout in the same cycle: tx_done wins.
- GAP: wait exactly GAP_CYCLES clocks, then make the post-byte decision.
- Post-byte decision: if lock=1 go to HOLD, else last_grant<=owner and go to IDLE. The first acceptance after IDLE is therefore at least 1 cycle later.
- HOLD: only requester owner is served.
  - req_valid[owner]=1: accept in that cycle (req_ready pulse, latch data, lock<=~req_last), go to SEND.
  - Otherwise count up; at HOLD_TIMEOUT-1 pulse err_abandon, clear lock, last_grant<=owner, go to IDLE.
  - Other requesters' req_valid is ignored in HOLD.
- Handshake: a requester must hold req_valid/req_data/req_last stable until it sees its req_ready. At most one req_ready bit is high per cycle, and never in SEND/WAIT_DONE/GAP.
- tx_done outside WAIT_DONE is ignored. tx_data changes only on an acceptance cycle.
- rst asserted mid-byte: immediate return to the reset state. Any in-flight byte is the transmitter's concern; no error pulse.
- Counter widths: clog2 of the largest of DONE_TIMEOUT, HOLD_TIMEOUT, GAP_CYCLES, plus 1.
- Throughput at GAP_CYCLES=0: one byte per (transmitter frame + 2) clocks.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (IDLE=0, SEND=1, WAIT_DONE=2, GAP=3, HOLD=4);
  - the clk_div derivation;
  - the default timeout multipliers (12, 16), so uart_tx and future uart_rx share them.
- One sub-module: uart_rr_pick, a combinational round-robin picker.
  - Inputs: req_valid, last_grant.
  - Outputs: any, idx.
  - Kept separate so it can be unit-tested exhaustively for N_REQ up to 8.

Test Plan:
- Single byte: req_valid[2]=1, data 8'h41, last=1 → req_ready[2] at cycle 1, tx_start at cycle 2 with tx_data=8'h41, owner=2; after model tx_done, busy=0 the following cycle.
- Fairness: all 4 requesters hold valid with single-byte messages ('A','B','C','D') → grant order 0,1,2,3,0; each requester gets exactly 1 of every 4 grants over 20 bytes.
- Lock: requester 1 sends "HI\n" (last on '\n') while requester 0 is continuously valid → tx_data sequence 'H','I','\n', then requester 0's byte; no req_ready[0] during the message.
- Done timeout: transmitter model never pulses tx_done, defaults → err_timeout exactly 2808 clocks (12*234) after tx_start; state IDLE; the next requester is served.
- Abandon: requester 3 sends a non-last byte, then drops valid → err_abandon 3744 clocks (16*234) after entering HOLD; requester 0 is granted next.
- Reset mid-message and GAP: rst for 1 cycle during WAIT_DONE → all outputs at reset values the next cycle. Then with GAP_CYCLES=5, back-to-back bytes → exactly 5 idle clocks between tx_done and the next req_ready.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART blocks: the scheduler state encoding, the baud divisor
// derivation and the default timeout multipliers in units of bit periods.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_DONE = 3'd2,
    GAP       = 3'd3,
    HOLD      = 3'd4
  } sched_state_t;

  localparam int DONE_TIMEOUT_MULT = 12;
  localparam int HOLD_TIMEOUT_MULT = 16;

  function automatic int calc_clk_div(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request found by scanning
// upward from the slot after last_grant, wrapping around.
module uart_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic                     any,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(N_REQ);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    return IDX_W'((int'(base) + k) % N_REQ);
  endfunction

  // k = N_REQ lands back on last_grant itself, so it is the lowest-priority candidate.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!any && req_valid[wrap_add(last_grant, k)]) begin
        any = 1'b1;
        idx = wrap_add(last_grant, k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one byte-level UART transmitter among N_REQ requesters,
// locking ownership for whole messages and supervising both the transmitter and the owner.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int clk_rate     = 27000000,
  parameter int baud_rate    = 115200,
  parameter int GAP_CYCLES   = 0,
  parameter int DONE_TIMEOUT = DONE_TIMEOUT_MULT * calc_clk_div(clk_rate, baud_rate),
  parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_MULT * calc_clk_div(clk_rate, baud_rate)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_done,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     err_timeout,
  output logic                     err_abandon
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(max3(DONE_TIMEOUT, HOLD_TIMEOUT, GAP_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);

  sched_state_t     state, state_n;
  logic             lock, lock_n;
  logic [IDX_W-1:0] last_grant, last_grant_n;
  logic [IDX_W-1:0] owner_n;
  logic [7:0]       tx_data_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             post_byte;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .any        (pick_any),
    .idx        (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lock       <= 1'b0;
      last_grant <= LAST_INIT;
      owner      <= '0;
      tx_data    <= 8'h00;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      lock       <= lock_n;
      last_grant <= last_grant_n;
      owner      <= owner_n;
      tx_data    <= tx_data_n;
      cnt        <= cnt_n;
    end
  end

  // One counter serves the done, gap and hold timers since only one runs at a time.
  always_comb begin
    state_n      = state;
    lock_n       = lock;
    last_grant_n = last_grant;
    owner_n      = owner;
    tx_data_n    = tx_data;
    cnt_n        = cnt;
    req_ready    = '0;
    tx_start     = 1'b0;
    err_timeout  = 1'b0;
    err_abandon  = 1'b0;
    post_byte    = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_any) begin
          req_ready[pick_idx] = 1'b1;
          owner_n             = pick_idx;
          tx_data_n           = req_data[{pick_idx, 3'b000} +: 8];
          lock_n              = ~req_last[pick_idx];
          state_n             = SEND;
        end
      end
      SEND: begin
        tx_start = 1'b1;
        cnt_n    = '0;
        state_n  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (GAP_CYCLES > 0) begin
            cnt_n   = '0;
            state_n = GAP;
          end else begin
            post_byte = 1'b1;
          end
        end else if (cnt == DONE_LAST) begin
          err_timeout  = 1'b1;
          lock_n       = 1'b0;
          last_grant_n = owner;
          state_n      = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) post_byte = 1'b1;
        else                 cnt_n = cnt + CNT_W'(1);
      end
      HOLD: begin
        if (req_valid[owner]) begin
          req_ready[owner] = 1'b1;
          tx_data_n        = req_data[{owner, 3'b000} +: 8];
          lock_n           = ~req_last[owner];
          state_n          = SEND;
        end else if (cnt == HOLD_LAST) begin
          err_abandon  = 1'b1;
          lock_n       = 1'b0;
          last_grant_n = owner;
          state_n      = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Shared exit after a completed byte: keep the owner while its message is open.
    if (post_byte) begin
      cnt_n = '0;
      if (lock) begin
        state_n = HOLD;
      end else begin
        last_grant_n = owner;
        state_n      = IDLE;
      end
    end

    if (rst) begin
      req_ready   = '0;
      tx_start    = 1'b0;
      err_timeout = 1'b0;
      err_abandon = 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule
